program_sequencer: RTL and testbench

Automatic instruction sequencer for the 10-bit processor. It holds a small program memory loaded from the switches and presents each instruction on the IR input of the processor controller. It generates the per-timestep strobes that replace the manual clock button, and advances the program counter when the controller signals instruction completion. It sits between the board inputs (debounced buttons and switches) and the processor's instruction register and timestep clock.

---
 rtl/program_sequencer.sv | 154 +++++++++++++++
 tb/tb_program_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: program memory, timestep strobe generator and PC
// sequencing that feeds the 10-bit processor controller.
module program_sequencer #(
    parameter int IW       = 10,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int STEP_DIV = 4
) (
    input  logic          CLK50M,
    input  logic          RSTb,
    input  logic [IW-1:0] DIN,
    input  logic          LOAD,
    input  logic          PCLR,
    input  logic          RUN,
    input  logic          STEP,
    input  logic          DONE,
    output logic [IW-1:0] IR,
    output logic          TSTEP,
    output logic [AW-1:0] PC,
    output logic [AW:0]   LEN,
    output logic [1:0]    STATE,
    output logic          HALTED,
    output logic          FULL,
    output logic          ERR
);

    localparam int DW     = $clog2(STEP_DIV);
    localparam int MAX_TS = 4;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        NEXT  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  mem_q [DEPTH];
    logic [IW-1:0]  ir_q, ir_d;
    logic           tstep_q, tstep_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW:0]    len_q, len_d;
    logic           err_q, err_d;
    logic           sstep_q, sstep_d;
    logic [DW-1:0]  div_q, div_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           mem_we;
    logic           full;
    logic           last_div;
    logic [AW:0]    pc_inc;

    assign full     = (len_q == (AW+1)'(DEPTH));
    assign last_div = (div_q == DW'(STEP_DIV - 1));
    assign pc_inc   = {1'b0, pc_q} + (AW+1)'(1);

    // Next-state logic: program editing in HALT, fetch/exec/advance otherwise
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        len_d   = len_q;
        err_d   = err_q;
        sstep_d = sstep_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        unique case (state_q)
            HALT: begin
                if (PCLR) begin
                    len_d = '0;
                    pc_d  = '0;
                    err_d = 1'b0;
                end else if (LOAD && !full) begin
                    mem_we = 1'b1;
                    len_d  = len_q + (AW+1)'(1);
                end
                // A clear in the same cycle empties the program, so no start
                if ((RUN || STEP) && len_q != '0 && !PCLR) begin
                    state_d = FETCH;
                    sstep_d = !RUN;
                end
            end
            FETCH: begin
                ir_d    = mem_q[pc_q];
                div_d   = '0;
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                if (last_div) begin
                    div_d = '0;
                    cnt_d = cnt_q + 3'd1;
                    if (DONE) begin
                        state_d = NEXT;
                    end else if (cnt_q == 3'(MAX_TS - 1)) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            NEXT: begin
                pc_d    = (pc_inc == len_q) ? '0 : pc_inc[AW-1:0];
                state_d = (RUN && !sstep_q) ? FETCH : HALT;
            end
            default: state_d = HALT;
        endcase
        // Strobe is registered: raised for the cycle the divider sits at its top
        tstep_d = (state_d == EXEC) && (div_d == DW'(STEP_DIV - 1));
    end

    // Control and datapath registers
    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= HALT;
            ir_q    <= '0;
            tstep_q <= 1'b0;
            pc_q    <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            sstep_q <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            tstep_q <= tstep_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            err_q   <= err_d;
            sstep_q <= sstep_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    // Program memory write port; contents need no reset
    always_ff @(posedge CLK50M) begin
        if (mem_we) begin
            mem_q[len_q[AW-1:0]] <= DIN;
        end
    end

    assign IR     = ir_q;
    assign TSTEP  = tstep_q;
    assign PC     = pc_q;
    assign LEN    = len_q;
    assign STATE  = state_q;
    assign HALTED = (state_q == HALT);
    assign FULL   = full;
    assign ERR    = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and randomized program runs checked
// against a cycle-count model of fetch/exec/next timing.
module tb_program_sequencer;

    localparam int IW    = 10;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int P     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] DIN;
    logic          LOAD, PCLR, RUN, STEP, DONE;
    logic [IW-1:0] IR;
    logic          TSTEP;
    logic [AW-1:0] PC;
    logic [AW:0]   LEN;
    logic [1:0]    STATE;
    logic          HALTED, FULL, ERR;

    int n_chk  = 0;
    int n_pass = 0;

    logic [IW-1:0] mem_m [DEPTH];
    int            len_m = 0;
    int            pc_m  = 0;
    int            err_m = 0;

    always #5 clk = ~clk;

    program_sequencer #(
        .IW(IW), .DEPTH(DEPTH), .AW(AW), .STEP_DIV(P)
    ) dut (
        .CLK50M(clk), .RSTb(rst_n), .DIN(DIN), .LOAD(LOAD),
        .PCLR(PCLR), .RUN(RUN), .STEP(STEP), .DONE(DONE),
        .IR(IR), .TSTEP(TSTEP), .PC(PC), .LEN(LEN), .STATE(STATE),
        .HALTED(HALTED), .FULL(FULL), .ERR(ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [IW-1:0] w);
        DIN  = w;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        if (len_m < DEPTH) begin
            mem_m[len_m] = w;
            len_m++;
        end
    endtask

    task automatic pclr();
        PCLR = 1'b1;
        tick();
        PCLR = 1'b0;
        len_m = 0;
        pc_m  = 0;
        err_m = 0;
    endtask

    // ks[i] = strobe on which DONE is given for instruction i (0 = never)
    task automatic run_seq(input string tag, input int ks[$],
                           input bit runmode);
        int            exp_cyc[$];
        logic [IW-1:0] exp_ir[$];
        int            exp_pc[$];
        int            obs_cyc[$];
        logic [IW-1:0] obs_ir[$];
        int            obs_pc[$];
        int c, pc, end_c, cyc, s, idx, k, n, m;
        c = 0; pc = pc_m; end_c = 0; s = 0; idx = 0;
        foreach (ks[i]) begin
            k = ks[i];
            n = (k == 0) ? 4 : k;
            for (int j = 1; j <= n; j++) begin
                exp_cyc.push_back(c + 1 + P * j);
                exp_ir.push_back(mem_m[pc]);
                exp_pc.push_back(pc);
            end
            if (k == 0) begin
                err_m = 1;
                end_c = c + 2 + P * 4;
                break;
            end
            pc    = (pc + 1 == len_m) ? 0 : pc + 1;
            end_c = c + 3 + P * k;
            c     = c + 2 + P * k;
        end
        pc_m = pc;

        if (runmode) RUN = 1'b1;
        else STEP = 1'b1;
        tick();
        cyc  = 1;
        STEP = 1'b0;
        while (!HALTED && cyc < 400) begin
            DONE = 1'b0;
            if (cyc == 3) begin
                DIN  = IW'($urandom);
                LOAD = 1'b1;
                STEP = 1'b1;
            end else begin
                LOAD = 1'b0;
                STEP = 1'b0;
            end
            if (TSTEP) begin
                obs_cyc.push_back(cyc);
                obs_ir.push_back(IR);
                obs_pc.push_back(int'(PC));
                s++;
                if (idx < ks.size() && ks[idx] != 0 && s == ks[idx]) begin
                    DONE = 1'b1;
                    s = 0;
                    idx++;
                    if (idx == ks.size()) RUN = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        DONE = 1'b0; LOAD = 1'b0; STEP = 1'b0; RUN = 1'b0;

        check({tag, ".end_cycle"}, cyc, end_c);
        check({tag, ".halted"}, HALTED, 1);
        check({tag, ".n_strobes"}, obs_cyc.size(), exp_cyc.size());
        m = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size()
                                              : exp_cyc.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.strobe%0d_cyc", tag, i), obs_cyc[i], exp_cyc[i]);
            check($sformatf("%s.strobe%0d_ir", tag, i), obs_ir[i], exp_ir[i]);
            check($sformatf("%s.strobe%0d_pc", tag, i), obs_pc[i], exp_pc[i]);
        end
        check({tag, ".pc"}, PC, pc_m);
        check({tag, ".err"}, ERR, err_m);
        check({tag, ".len"}, LEN, len_m);
    endtask

    initial begin
        int q[$];
        int ts, nh, nk;
        bit rm;
        DIN = '0; LOAD = 0; PCLR = 0; RUN = 0; STEP = 0; DONE = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst.state", STATE, 0);
        check("rst.ir", IR, 0);
        check("rst.tstep", TSTEP, 0);
        check("rst.pc", PC, 0);
        check("rst.len", LEN, 0);
        check("rst.err", ERR, 0);
        check("rst.halted", HALTED, 1);
        check("rst.full", FULL, 0);
        tick();
        rst_n = 1'b1;
        tick();

        RUN = 1'b1;
        ts = 0; nh = 0;
        repeat (12) begin
            tick();
            if (TSTEP) ts++;
            if (!HALTED) nh++;
        end
        RUN = 1'b0;
        check("empty.tsteps", ts, 0);
        check("empty.not_halted", nh, 0);

        load_word(10'h101);
        load_word(10'h202);
        load_word(10'h303);
        check("load3.len", LEN, 3);
        check("load3.full", FULL, 0);

        q = {2};
        run_seq("step", q, 1'b0);

        q = {3, 3, 3, 3};
        run_seq("run_wrap", q, 1'b1);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 2)) load_word(IW'($urandom));
            rm = 1'($urandom);
            nk = rm ? $urandom_range(1, 5) : 1;
            q = {};
            for (int i = 0; i < nk; i++) q.push_back($urandom_range(1, 4));
            run_seq($sformatf("rand%0d", r), q, rm);
        end

        q = {0};
        run_seq("timeout", q, 1'b0);
        pclr();
        check("pclr.err", ERR, 0);
        check("pclr.len", LEN, 0);
        check("pclr.pc", PC, 0);

        for (int i = 0; i < 17; i++) load_word(IW'($urandom));
        check("full.len", LEN, DEPTH);
        check("full.full", FULL, 1);
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(1);
        run_seq("full_run", q, 1'b1);

        DIN = IW'($urandom);
        PCLR = 1'b1;
        LOAD = 1'b1;
        tick();
        PCLR = 1'b0;
        LOAD = 1'b0;
        len_m = 0; pc_m = 0; err_m = 0;
        check("pclr_load.len", LEN, 0);
        check("pclr_load.full", FULL, 0);

        load_word(10'h155);
        load_word(10'h2aa);
        RUN = 1'b1;
        nh = 0;
        while (!TSTEP && nh < 20) begin
            tick();
            nh++;
        end
        check("midrst.tstep_seen", TSTEP, 1);
        rst_n = 1'b0;
        #1;
        check("midrst.ir", IR, 0);
        check("midrst.tstep", TSTEP, 0);
        check("midrst.pc", PC, 0);
        check("midrst.len", LEN, 0);
        check("midrst.halted", HALTED, 1);
        check("midrst.err", ERR, 0);
        RUN = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
